video_timing_gen: RTL and testbench

- Parametrised raster timing generator: successor to the fixed 336x240 arcade timing block.
- Produces pixel and line counters, a lookahead fetch position, blanking, sync, a blanked RGB output and frame/line strobes for the game core and arcade_video.
- Runs on one system clock with a pixel clock-enable. Adds signed sync offsets latched per frame, a frame counter and vblank/line strobes.

---
 rtl/vtg_pkg.sv | 35 +++
 rtl/video_timing_gen_if.sv | 37 +++
 rtl/vtg_axis_counter.sv | 47 ++++
 rtl/video_timing_gen.sv | 111 +++++++++++
 tb/tb_video_timing_gen.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vtg_pkg.sv
// Shared definitions for the video timing generator: the default 336x240
// arcade profile, the latched sync-offset pair and the sync clamp helper.
package vtg_pkg;

  localparam int VTG_H_TOTAL  = 456;
  localparam int VTG_H_ACTIVE = 336;
  localparam int VTG_HS_START = 360;
  localparam int VTG_HS_WIDTH = 24;
  localparam int VTG_V_TOTAL  = 262;
  localparam int VTG_V_ACTIVE = 240;
  localparam int VTG_VS_START = 240;
  localparam int VTG_VS_WIDTH = 3;
  localparam int VTG_H_LEAD   = 1;
  localparam int VTG_RGB_W    = 8;
  localparam int VTG_OFFS_W   = 5;

  // Sync arithmetic is 11-bit signed so nominal + offset never wraps.
  typedef logic signed [10:0] s11_t;

  // Offsets as latched at the frame boundary, already sign-extended.
  typedef struct packed {
    s11_t h;
    s11_t v;
  } offs_pair_t;

  // Clamp a nominal sync start into [lo, hi].
  function automatic logic [10:0] clamp_sync(input s11_t nom, input s11_t lo, input s11_t hi);
    logic [10:0] r;
    if (nom < lo)      r = lo;
    else if (nom > hi) r = hi;
    else               r = nom;
    return r;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Bus between the timing generator and its consumers (game core, arcade_video).
// master = generator side, slave = consumer side.
interface video_timing_gen_if
  import vtg_pkg::*;
#(
  parameter int RGB_W  = VTG_RGB_W,
  parameter int OFFS_W = VTG_OFFS_W
);
  logic                     ce_pix;
  logic signed [OFFS_W-1:0] hoffs;
  logic signed [OFFS_W-1:0] voffs;
  logic [8:0]               irq_line;
  logic [RGB_W-1:0]         rgb_in;
  logic [8:0]               hpos;
  logic [8:0]               vpos;
  logic                     hblank;
  logic                     vblank;
  logic                     hsync_n;
  logic                     vsync_n;
  logic [RGB_W-1:0]         rgb_out;
  logic                     frame_start;
  logic                     vblank_start;
  logic [7:0]               frame_cnt;
  logic                     line_irq;

  modport master (
    input  ce_pix, hoffs, voffs, irq_line, rgb_in,
    output hpos, vpos, hblank, vblank, hsync_n, vsync_n, rgb_out,
           frame_start, vblank_start, frame_cnt, line_irq
  );

  modport slave (
    output ce_pix, hoffs, voffs, irq_line, rgb_in,
    input  hpos, vpos, hblank, vblank, hsync_n, vsync_n, rgb_out,
           frame_start, vblank_start, frame_cnt, line_irq
  );
endinterface

// File: rtl/vtg_axis_counter.sv
// One raster axis: wrap counter 0..TOTAL-1 with registered blank and sync
// decode. Blank/sync follow the post-increment count on every ce tick, so
// they change on the same tick as the counter. inc gates counting only.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int TOTAL  = VTG_H_TOTAL,
  parameter int ACTIVE = VTG_H_ACTIVE,
  parameter int SYNC_W = VTG_HS_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        inc,
  input  logic [10:0] sync_b,
  output logic [8:0]  cnt,
  output logic [8:0]  nxt,
  output logic        last,
  output logic        active,
  output logic        blank,
  output logic        sync_n
);
  logic [10:0] nxt_w;

  assign last   = (cnt == 9'(TOTAL - 1));
  assign active = (cnt < 9'(ACTIVE));
  assign nxt_w  = {2'b00, nxt};

  // Value the counter takes on this ce tick.
  always_comb begin
    nxt = cnt;
    if (inc) nxt = last ? 9'd0 : cnt + 9'd1;
  end

  // Counter plus blank/sync registers derived from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      blank  <= 1'b1;
      sync_n <= 1'b1;
    end else if (ce) begin
      cnt    <= nxt;
      blank  <= (nxt >= 9'(ACTIVE));
      sync_n <= !((nxt_w >= sync_b) && (nxt_w < sync_b + 11'(SYNC_W)));
    end
  end
endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator (336x240 arcade profile by default).
// Sync offsets are latched at the frame boundary and clamped into blanking.
// Optional: define VTG_LINE_IRQ_EN to build the raster-compare line_irq.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_TOTAL  = VTG_H_TOTAL,
  parameter int H_ACTIVE = VTG_H_ACTIVE,
  parameter int HS_START = VTG_HS_START,
  parameter int HS_WIDTH = VTG_HS_WIDTH,
  parameter int V_TOTAL  = VTG_V_TOTAL,
  parameter int V_ACTIVE = VTG_V_ACTIVE,
  parameter int VS_START = VTG_VS_START,
  parameter int VS_WIDTH = VTG_VS_WIDTH,
  parameter int H_LEAD   = VTG_H_LEAD,
  parameter int RGB_W    = VTG_RGB_W,
  parameter int OFFS_W   = VTG_OFFS_W
) (
  input  logic               clk_sys,
  input  logic               RESET,
  video_timing_gen_if.master bus
);

  if (H_ACTIVE >= H_TOTAL || V_ACTIVE >= V_TOTAL ||
      HS_WIDTH > H_TOTAL - H_ACTIVE || VS_WIDTH > V_TOTAL - V_ACTIVE ||
      H_TOTAL > 512 || V_TOTAL > 512 || H_LEAD >= H_TOTAL || OFFS_W > 10) begin : g_param_err
    $error("video_timing_gen: illegal timing parameters");
  end

  logic [8:0]  h_cnt, h_nxt_unused, v_cnt, v_nxt;
  logic        h_last, h_active, h_blank, h_sync_n;
  logic        v_last, v_active, v_blank, v_sync_n;
  logic [10:0] hs_b, vs_b;
  logic [9:0]  hsum;
  logic        frame_tick;
  offs_pair_t  offs_l;
  logic [RGB_W-1:0] rgb_q;
  logic        frame_start_q, vblank_start_q;
  logic [7:0]  frame_cnt_q;

  assign hs_b = clamp_sync(s11_t'(HS_START) + (offs_l.h <<< 1),
                           s11_t'(H_ACTIVE), s11_t'(H_TOTAL - HS_WIDTH));
  assign vs_b = clamp_sync(s11_t'(VS_START) + offs_l.v,
                           s11_t'(V_ACTIVE), s11_t'(V_TOTAL - VS_WIDTH));

  vtg_axis_counter #(.TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_W(HS_WIDTH)) u_h (
    .clk(clk_sys), .rst(RESET), .ce(bus.ce_pix), .inc(1'b1), .sync_b(hs_b),
    .cnt(h_cnt), .nxt(h_nxt_unused), .last(h_last), .active(h_active),
    .blank(h_blank), .sync_n(h_sync_n)
  );

  // Lines advance on the tick where the pixel counter wraps.
  vtg_axis_counter #(.TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_W(VS_WIDTH)) u_v (
    .clk(clk_sys), .rst(RESET), .ce(bus.ce_pix), .inc(h_last), .sync_b(vs_b),
    .cnt(v_cnt), .nxt(v_nxt), .last(v_last), .active(v_active),
    .blank(v_blank), .sync_n(v_sync_n)
  );

  assign frame_tick = bus.ce_pix & h_last & v_last;

  // Offsets, frame/vblank strobes and frame counter; strobes drop on idle clks.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      offs_l         <= '0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      frame_start_q  <= frame_tick;
      vblank_start_q <= bus.ce_pix & h_last & (v_nxt == 9'(V_ACTIVE));
      if (frame_tick) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        offs_l.h    <= {{(11 - OFFS_W){bus.hoffs[OFFS_W-1]}}, bus.hoffs};
        offs_l.v    <= {{(11 - OFFS_W){bus.voffs[OFFS_W-1]}}, bus.voffs};
      end
    end
  end

  // Blank the pixel of the current position; one ce of latency vs. hpos.
  always_ff @(posedge clk_sys) begin
    if (RESET)           rgb_q <= '0;
    else if (bus.ce_pix) rgb_q <= (h_active && v_active) ? bus.rgb_in : '0;
  end

`ifdef VTG_LINE_IRQ_EN
  logic line_irq_q;
  // Raster compare against irq_line sampled on the tick a line begins.
  always_ff @(posedge clk_sys) begin
    if (RESET) line_irq_q <= 1'b0;
    else       line_irq_q <= bus.ce_pix & h_last & (v_nxt == bus.irq_line);
  end
  assign bus.line_irq = line_irq_q;
`else
  logic unused_irq_line;
  assign unused_irq_line = ^bus.irq_line;
  assign bus.line_irq    = 1'b0;
`endif

  assign hsum             = {1'b0, h_cnt} + 10'(H_LEAD);
  assign bus.hpos         = (hsum >= 10'(H_TOTAL)) ? 9'(hsum - 10'(H_TOTAL)) : hsum[8:0];
  assign bus.vpos         = v_cnt;
  assign bus.hblank       = h_blank;
  assign bus.vblank       = v_blank;
  assign bus.hsync_n      = h_sync_n;
  assign bus.vsync_n      = v_sync_n;
  assign bus.rgb_out      = rgb_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.vblank_start = vblank_start_q;
  assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default-profile instance for line-level timing, and a
// shrunk 20x10 profile instance for frame-level behaviour.
// Small profile: H 20/12, hs 14 w3 clamp [12,17]; V 10/6, vs 7 w2 clamp [6,8].
module tb_video_timing_gen;

  localparam bit IRQ_ON =
`ifdef VTG_LINE_IRQ_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk_sys = 1'b0;
  logic       RESET   = 1'b1;
  logic       ce_pix  = 1'b0;
  logic [4:0] hoffs   = '0;
  logic [4:0] voffs   = '0;
  logic [8:0] irq_line = '0;
  logic [7:0] rgb_in  = 8'hFF;
  int checks = 0;
  int errors = 0;
  int tk = 0;

  always #5 clk_sys = ~clk_sys;

  video_timing_gen_if #(.RGB_W(8), .OFFS_W(5)) bd ();
  video_timing_gen_if #(.RGB_W(8), .OFFS_W(5)) bs ();

  assign bd.ce_pix = ce_pix;  assign bs.ce_pix = ce_pix;
  assign bd.hoffs  = hoffs;   assign bs.hoffs  = hoffs;
  assign bd.voffs  = voffs;   assign bs.voffs  = voffs;
  assign bd.irq_line = irq_line; assign bs.irq_line = irq_line;
  assign bd.rgb_in = rgb_in;  assign bs.rgb_in = rgb_in;

  video_timing_gen u_def (.clk_sys(clk_sys), .RESET(RESET), .bus(bd));

  video_timing_gen #(
    .H_TOTAL(20), .H_ACTIVE(12), .HS_START(14), .HS_WIDTH(3),
    .V_TOTAL(10), .V_ACTIVE(6),  .VS_START(7),  .VS_WIDTH(2)
  ) u_small (.clk_sys(clk_sys), .RESET(RESET), .bus(bs));

  // One ce_pix tick every second clock; returns 1 time unit after the tick edge.
  task automatic step();
    @(posedge clk_sys); #1 ce_pix = 1'b1;
    @(posedge clk_sys); #1 ce_pix = 1'b0;
    tk++;
  endtask

  task automatic adv(input int t);
    while (tk < t) step();
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #1 RESET = 1'b1;
    repeat (5) begin @(posedge clk_sys); #1 ce_pix = ~ce_pix; end
    ce_pix = 1'b0; RESET = 1'b0; tk = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bd.hpos !== 9'd1) begin errors++; $display("FAIL rst_hpos: got %0d want 1", bd.hpos); end
    checks++; if (bd.vpos !== 9'd0) begin errors++; $display("FAIL rst_vpos: got %0d want 0", bd.vpos); end
    checks++; if (bd.hblank !== 1'b1) begin errors++; $display("FAIL rst_hblank: got %b want 1", bd.hblank); end
    checks++; if (bd.vblank !== 1'b1) begin errors++; $display("FAIL rst_vblank: got %b want 1", bd.vblank); end
    checks++; if (bd.hsync_n !== 1'b1) begin errors++; $display("FAIL rst_hsync_n: got %b want 1", bd.hsync_n); end
    checks++; if (bd.vsync_n !== 1'b1) begin errors++; $display("FAIL rst_vsync_n: got %b want 1", bd.vsync_n); end
    checks++; if (bd.rgb_out !== 8'h00) begin errors++; $display("FAIL rst_rgb: got %h want 00", bd.rgb_out); end
    checks++; if (bd.frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start: got %b want 0", bd.frame_start); end
    checks++; if (bd.vblank_start !== 1'b0) begin errors++; $display("FAIL rst_vblank_start: got %b want 0", bd.vblank_start); end
    checks++; if (bd.frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", bd.frame_cnt); end
    checks++; if (bd.line_irq !== 1'b0) begin errors++; $display("FAIL rst_line_irq: got %b want 0", bd.line_irq); end
    checks++; if (bs.hblank !== 1'b1) begin errors++; $display("FAIL rst_s_hblank: got %b want 1", bs.hblank); end
    checks++; if (bs.hpos !== 9'd1) begin errors++; $display("FAIL rst_s_hpos: got %0d want 1", bs.hpos); end
  endtask

  // Default profile, first line and the wrap into line 1.
  task automatic test_hline();
    do_reset(); rgb_in = 8'hFF;
    adv(1);
    checks++; if (bd.hpos !== 9'd2) begin errors++; $display("FAIL hl_hpos1: got %0d want 2", bd.hpos); end
    checks++; if (bd.hblank !== 1'b0) begin errors++; $display("FAIL hl_hblank1: got %b want 0", bd.hblank); end
    checks++; if (bd.vblank !== 1'b0) begin errors++; $display("FAIL hl_vblank1: got %b want 0", bd.vblank); end
    checks++; if (bd.rgb_out !== 8'hFF) begin errors++; $display("FAIL hl_rgb1: got %h want ff", bd.rgb_out); end
    checks++; if (bd.hsync_n !== 1'b1) begin errors++; $display("FAIL hl_hs1: got %b want 1", bd.hsync_n); end
    rgb_in = 8'h5A; adv(2); rgb_in = 8'hFF;
    checks++; if (bd.rgb_out !== 8'h5A) begin errors++; $display("FAIL hl_rgb_pass: got %h want 5a", bd.rgb_out); end
    adv(335);
    checks++; if (bd.hblank !== 1'b0) begin errors++; $display("FAIL hl_hblank335: got %b want 0", bd.hblank); end
    checks++; if (bd.hpos !== 9'd336) begin errors++; $display("FAIL hl_hpos335: got %0d want 336", bd.hpos); end
    adv(336);
    checks++; if (bd.hblank !== 1'b1) begin errors++; $display("FAIL hl_hblank336: got %b want 1", bd.hblank); end
    checks++; if (bd.rgb_out !== 8'hFF) begin errors++; $display("FAIL hl_rgb_lat: got %h want ff", bd.rgb_out); end
    adv(337);
    checks++; if (bd.rgb_out !== 8'h00) begin errors++; $display("FAIL hl_rgb_blank: got %h want 00", bd.rgb_out); end
    adv(359);
    checks++; if (bd.hsync_n !== 1'b1) begin errors++; $display("FAIL hl_hs359: got %b want 1", bd.hsync_n); end
    adv(360);
    checks++; if (bd.hsync_n !== 1'b0) begin errors++; $display("FAIL hl_hs360: got %b want 0", bd.hsync_n); end
    adv(383);
    checks++; if (bd.hsync_n !== 1'b0) begin errors++; $display("FAIL hl_hs383: got %b want 0", bd.hsync_n); end
    adv(384);
    checks++; if (bd.hsync_n !== 1'b1) begin errors++; $display("FAIL hl_hs384: got %b want 1", bd.hsync_n); end
    adv(455);
    checks++; if (bd.hpos !== 9'd0) begin errors++; $display("FAIL hl_hpos_wrap: got %0d want 0", bd.hpos); end
    checks++; if (bd.vpos !== 9'd0) begin errors++; $display("FAIL hl_vpos455: got %0d want 0", bd.vpos); end
    adv(456);
    checks++; if (bd.vpos !== 9'd1) begin errors++; $display("FAIL hl_vpos456: got %0d want 1", bd.vpos); end
    checks++; if (bd.hpos !== 9'd1) begin errors++; $display("FAIL hl_hpos456: got %0d want 1", bd.hpos); end
    checks++; if (bd.hblank !== 1'b0) begin errors++; $display("FAIL hl_hblank456: got %b want 0", bd.hblank); end
    checks++; if (bd.rgb_out !== 8'h00) begin errors++; $display("FAIL hl_rgb456: got %h want 00", bd.rgb_out); end
    checks++; if (bd.frame_start !== 1'b0) begin errors++; $display("FAIL hl_fs456: got %b want 0", bd.frame_start); end
    adv(457);
    checks++; if (bd.rgb_out !== 8'hFF) begin errors++; $display("FAIL hl_rgb457: got %h want ff", bd.rgb_out); end
  endtask

  // Small profile: vblank, vsync, frame wrap. Tick k -> (k%20, (k/20)%10).
  task automatic test_vertical();
    do_reset(); hoffs = '0; voffs = '0;
    adv(119);
    checks++; if (bs.vblank !== 1'b0) begin errors++; $display("FAIL v_vblank119: got %b want 0", bs.vblank); end
    checks++; if (bs.vpos !== 9'd5) begin errors++; $display("FAIL v_vpos119: got %0d want 5", bs.vpos); end
    adv(120);
    checks++; if (bs.vblank !== 1'b1) begin errors++; $display("FAIL v_vblank120: got %b want 1", bs.vblank); end
    checks++; if (bs.vblank_start !== 1'b1) begin errors++; $display("FAIL v_vbs120: got %b want 1", bs.vblank_start); end
    checks++; if (bs.hblank !== 1'b0) begin errors++; $display("FAIL v_hblank120: got %b want 0", bs.hblank); end
    checks++; if (bs.vsync_n !== 1'b1) begin errors++; $display("FAIL v_vs120: got %b want 1", bs.vsync_n); end
    adv(121);
    checks++; if (bs.vblank_start !== 1'b0) begin errors++; $display("FAIL v_vbs121: got %b want 0", bs.vblank_start); end
    checks++; if (bs.rgb_out !== 8'h00) begin errors++; $display("FAIL v_rgb121: got %h want 00", bs.rgb_out); end
    adv(139);
    checks++; if (bs.vsync_n !== 1'b1) begin errors++; $display("FAIL v_vs139: got %b want 1", bs.vsync_n); end
    adv(140);
    checks++; if (bs.vsync_n !== 1'b0) begin errors++; $display("FAIL v_vs140: got %b want 0", bs.vsync_n); end
    adv(179);
    checks++; if (bs.vsync_n !== 1'b0) begin errors++; $display("FAIL v_vs179: got %b want 0", bs.vsync_n); end
    adv(180);
    checks++; if (bs.vsync_n !== 1'b1) begin errors++; $display("FAIL v_vs180: got %b want 1", bs.vsync_n); end
    adv(199);
    checks++; if (bs.frame_start !== 1'b0) begin errors++; $display("FAIL v_fs199: got %b want 0", bs.frame_start); end
    checks++; if (bs.frame_cnt !== 8'd0) begin errors++; $display("FAIL v_fc199: got %0d want 0", bs.frame_cnt); end
    adv(200);
    checks++; if (bs.frame_start !== 1'b1) begin errors++; $display("FAIL v_fs200: got %b want 1", bs.frame_start); end
    checks++; if (bs.frame_cnt !== 8'd1) begin errors++; $display("FAIL v_fc200: got %0d want 1", bs.frame_cnt); end
    checks++; if (bs.vpos !== 9'd0) begin errors++; $display("FAIL v_vpos200: got %0d want 0", bs.vpos); end
    checks++; if (bs.vblank !== 1'b0) begin errors++; $display("FAIL v_vblank200: got %b want 0", bs.vblank); end
    adv(201);
    checks++; if (bs.frame_start !== 1'b0) begin errors++; $display("FAIL v_fs201: got %b want 0", bs.frame_start); end
  endtask

  task automatic test_line_irq();
    int n;
    do_reset(); irq_line = 9'd3;
    adv(59);
    checks++; if (bs.line_irq !== 1'b0) begin errors++; $display("FAIL irq_t59: got %b want 0", bs.line_irq); end
    adv(60);
    checks++; if (bs.line_irq !== IRQ_ON) begin errors++; $display("FAIL irq_t60: got %b want %b", bs.line_irq, IRQ_ON); end
    adv(61);
    checks++; if (bs.line_irq !== 1'b0) begin errors++; $display("FAIL irq_t61: got %b want 0", bs.line_irq); end
    irq_line = 9'd0;
    adv(200);
    checks++; if (bs.line_irq !== IRQ_ON) begin errors++; $display("FAIL irq_line0: got %b want %b", bs.line_irq, IRQ_ON); end
    irq_line = 9'd300; n = 0;
    while (tk < 400) begin step(); if (bs.line_irq === 1'b1) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL irq_out_of_range: got %0d pulses want 0", n); end
    irq_line = 9'd3; n = 0;
    while (tk < 600) begin step(); if (bs.line_irq === 1'b1) n++; end
    checks++; if (n != int'(IRQ_ON)) begin errors++; $display("FAIL irq_per_frame: got %0d pulses want %0d", n, IRQ_ON); end
  endtask

  // hoffs changed mid-frame: current frame keeps hs_b=14, next uses 14+2.
  task automatic test_midframe();
    do_reset(); hoffs = '0; voffs = '0;
    adv(65); hoffs = 5'd1;
    adv(93);
    checks++; if (bs.hsync_n !== 1'b1) begin errors++; $display("FAIL mid_hs93: got %b want 1", bs.hsync_n); end
    adv(94);
    checks++; if (bs.hsync_n !== 1'b0) begin errors++; $display("FAIL mid_hs94: got %b want 0", bs.hsync_n); end
    adv(97);
    checks++; if (bs.hsync_n !== 1'b1) begin errors++; $display("FAIL mid_hs97: got %b want 1", bs.hsync_n); end
    adv(215);
    checks++; if (bs.hsync_n !== 1'b1) begin errors++; $display("FAIL mid_hs215: got %b want 1", bs.hsync_n); end
    adv(216);
    checks++; if (bs.hsync_n !== 1'b0) begin errors++; $display("FAIL mid_hs216: got %b want 0", bs.hsync_n); end
    adv(218);
    checks++; if (bs.hsync_n !== 1'b0) begin errors++; $display("FAIL mid_hs218: got %b want 0", bs.hsync_n); end
    adv(219);
    checks++; if (bs.hsync_n !== 1'b1) begin errors++; $display("FAIL mid_hs219: got %b want 1", bs.hsync_n); end
    hoffs = '0;
  endtask

  // hoffs +15 -> 14+30 clamps to 17; voffs +5 -> 12 clamps to 8.
  // hoffs -16 -> 14-32 clamps to 12; voffs -1 -> 6.
  task automatic test_offset_clamp();
    do_reset(); hoffs = 5'h0F; voffs = 5'h05;
    adv(14);
    checks++; if (bs.hsync_n !== 1'b0) begin errors++; $display("FAIL cl_hs14: got %b want 0", bs.hsync_n); end
    adv(216);
    checks++; if (bs.hsync_n !== 1'b1) begin errors++; $display("FAIL cl_hs216: got %b want 1", bs.hsync_n); end
    adv(217);
    checks++; if (bs.hsync_n !== 1'b0) begin errors++; $display("FAIL cl_hs217: got %b want 0", bs.hsync_n); end
    adv(219);
    checks++; if (bs.hsync_n !== 1'b0) begin errors++; $display("FAIL cl_hs219: got %b want 0", bs.hsync_n); end
    adv(220);
    checks++; if (bs.hsync_n !== 1'b1) begin errors++; $display("FAIL cl_hs220: got %b want 1", bs.hsync_n); end
    adv(359);
    checks++; if (bs.vsync_n !== 1'b1) begin errors++; $display("FAIL cl_vs359: got %b want 1", bs.vsync_n); end
    adv(360);
    checks++; if (bs.vsync_n !== 1'b0) begin errors++; $display("FAIL cl_vs360: got %b want 0", bs.vsync_n); end
    adv(399);
    checks++; if (bs.vsync_n !== 1'b0) begin errors++; $display("FAIL cl_vs399: got %b want 0", bs.vsync_n); end
    hoffs = 5'h10; voffs = 5'h1F;
    adv(400);
    checks++; if (bs.vsync_n !== 1'b1) begin errors++; $display("FAIL cl_vs400: got %b want 1", bs.vsync_n); end
    checks++; if (bs.frame_cnt !== 8'd2) begin errors++; $display("FAIL cl_fc400: got %0d want 2", bs.frame_cnt); end
    adv(411);
    checks++; if (bs.hsync_n !== 1'b1) begin errors++; $display("FAIL cl_hs411: got %b want 1", bs.hsync_n); end
    adv(412);
    checks++; if (bs.hsync_n !== 1'b0) begin errors++; $display("FAIL cl_hs412: got %b want 0", bs.hsync_n); end
    adv(414);
    checks++; if (bs.hsync_n !== 1'b0) begin errors++; $display("FAIL cl_hs414: got %b want 0", bs.hsync_n); end
    adv(415);
    checks++; if (bs.hsync_n !== 1'b1) begin errors++; $display("FAIL cl_hs415: got %b want 1", bs.hsync_n); end
    adv(519);
    checks++; if (bs.vsync_n !== 1'b1) begin errors++; $display("FAIL cl_vs519: got %b want 1", bs.vsync_n); end
    adv(520);
    checks++; if (bs.vsync_n !== 1'b0) begin errors++; $display("FAIL cl_vs520: got %b want 0", bs.vsync_n); end
    adv(559);
    checks++; if (bs.vsync_n !== 1'b0) begin errors++; $display("FAIL cl_vs559: got %b want 0", bs.vsync_n); end
    adv(560);
    checks++; if (bs.vsync_n !== 1'b1) begin errors++; $display("FAIL cl_vs560: got %b want 1", bs.vsync_n); end
    hoffs = '0; voffs = '0;
  endtask

  // Reset with ce_pix low in frame 1, line 7 (inside vsync).
  task automatic test_reset_midframe();
    do_reset(); hoffs = '0; voffs = '0;
    adv(350);
    checks++; if (bs.vsync_n !== 1'b0) begin errors++; $display("FAIL rm_vs350: got %b want 0", bs.vsync_n); end
    checks++; if (bs.frame_cnt !== 8'd1) begin errors++; $display("FAIL rm_fc350: got %0d want 1", bs.frame_cnt); end
    @(posedge clk_sys); #1 RESET = 1'b1;
    @(posedge clk_sys); #1 RESET = 1'b0; tk = 0;
    checks++; if (bs.hpos !== 9'd1) begin errors++; $display("FAIL rm_hpos: got %0d want 1", bs.hpos); end
    checks++; if (bs.vpos !== 9'd0) begin errors++; $display("FAIL rm_vpos: got %0d want 0", bs.vpos); end
    checks++; if (bs.vblank !== 1'b1) begin errors++; $display("FAIL rm_vblank: got %b want 1", bs.vblank); end
    checks++; if (bs.vsync_n !== 1'b1) begin errors++; $display("FAIL rm_vsync_n: got %b want 1", bs.vsync_n); end
    checks++; if (bs.frame_cnt !== 8'd0) begin errors++; $display("FAIL rm_fc: got %0d want 0", bs.frame_cnt); end
    checks++; if (bs.rgb_out !== 8'h00) begin errors++; $display("FAIL rm_rgb: got %h want 00", bs.rgb_out); end
    adv(1);
    checks++; if (bs.hpos !== 9'd2) begin errors++; $display("FAIL rm_hpos1: got %0d want 2", bs.hpos); end
    checks++; if (bs.vpos !== 9'd0) begin errors++; $display("FAIL rm_vpos1: got %0d want 0", bs.vpos); end
    checks++; if (bs.vblank !== 1'b0) begin errors++; $display("FAIL rm_vblank1: got %b want 0", bs.vblank); end
    checks++; if (bs.frame_start !== 1'b0) begin errors++; $display("FAIL rm_fs1: got %b want 0", bs.frame_start); end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_vertical();
    test_line_irq();
    test_midframe();
    test_offset_clamp();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
